// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// mux_rr_arbiter : two-source round-robin arbiter feeding one registered 2:1 mux
// Optional packet lock enabled by defining MUX_LOCK_EN.
// Revision: 1.0
// ============================================================================
module mux_rr_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_src,
  input  logic             out_ready
);

  logic load_en;
  logic allow_a;
  logic allow_b;
  logic want_a;
  logic want_b;
  logic sel_b;
  logic prio;
  logic xfer_a;
  logic xfer_b;

  assign load_en = !out_valid || out_ready;

`ifdef MUX_LOCK_EN
  logic lock;
  logic lock_src;

  // A locked packet excludes the other source even while the owner is idle.
  assign allow_a = !lock || !lock_src;
  assign allow_b = !lock || lock_src;
`else
  assign allow_a = 1'b1;
  assign allow_b = 1'b1;
`endif

  assign want_a  = a_valid && allow_a;
  assign want_b  = b_valid && allow_b;
  assign sel_b   = want_b && (!want_a || prio);

  assign a_ready = load_en && want_a && !sel_b;
  assign b_ready = load_en && sel_b;
  assign xfer_a  = a_valid && a_ready;
  assign xfer_b  = b_valid && b_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= 1'b0;
      prio      <= 1'b0;
    end else if (load_en) begin
      if (xfer_a) begin
        out_valid <= 1'b1;
        out_data  <= a_data;
        out_last  <= a_last;
        out_src   <= 1'b0;
        prio      <= 1'b1;
      end else if (xfer_b) begin
        out_valid <= 1'b1;
        out_data  <= b_data;
        out_last  <= b_last;
        out_src   <= 1'b1;
        prio      <= 1'b0;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MUX_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock     <= 1'b0;
      lock_src <= 1'b0;
    end else if (xfer_a) begin
      lock     <= !a_last;
      lock_src <= 1'b0;
    end else if (xfer_b) begin
      lock     <= !b_last;
      lock_src <= 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mux_rr_arbiter : directed + randomized checks against a behavioural model
// Revision: 1.0
// ============================================================================
module tb_mux_rr_arbiter;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         a_valid, a_last, a_ready;
  logic [W-1:0] a_data;
  logic         b_valid, b_last, b_ready;
  logic [W-1:0] b_data;
  logic         out_valid, out_last, out_src, out_ready;
  logic [W-1:0] out_data;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: the beat the output register should hold, plus arbitration state.
  logic         m_valid, m_last, m_src, m_prio, m_lock, m_lsrc;
  logic [W-1:0] m_data;
  int           last_grant;

  mux_rr_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_src(out_src), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_data = '0; m_last = 0; m_src = 0;
    m_prio = 0; m_lock = 0; m_lsrc = 0;
  endtask

  // 0 = no grant, 1 = a, 2 = b
  function automatic int model_grant();
    bit ca, cb;
    if (m_valid && !out_ready) return 0;
    ca = a_valid;
    cb = b_valid;
`ifdef MUX_LOCK_EN
    if (m_lock) begin
      ca = ca && (m_lsrc == 1'b0);
      cb = cb && (m_lsrc == 1'b1);
    end
`endif
    if (ca && cb) return m_prio ? 2 : 1;
    if (ca) return 1;
    if (cb) return 2;
    return 0;
  endfunction

  // Inputs are already driven (just after a negedge); check, predict, advance.
  task automatic cycle();
    int g;
    #1;
    g = model_grant();
    last_grant = g;
    check("a_ready",   a_ready,   g == 1);
    check("b_ready",   b_ready,   g == 2);
    check("out_valid", out_valid, m_valid);
    check("out_data",  out_data,  m_data);
    check("out_last",  out_last,  m_last);
    check("out_src",   out_src,   m_src);
    if (g == 1) begin
      m_valid = 1; m_data = a_data; m_last = a_last; m_src = 0;
      m_prio = 1; m_lock = !a_last; m_lsrc = 0;
    end else if (g == 2) begin
      m_valid = 1; m_data = b_data; m_last = b_last; m_src = 1;
      m_prio = 0; m_lock = !b_last; m_lsrc = 1;
    end else if (!m_valid || out_ready) begin
      m_valid = 0;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic av, input logic [W-1:0] ad, input logic al,
                       input logic bv, input logic [W-1:0] bd, input logic bl,
                       input logic ordy);
    a_valid = av; a_data = ad; a_last = al;
    b_valid = bv; b_data = bd; b_last = bl;
    out_ready = ordy;
  endtask

  initial begin
    logic [W-1:0] tie_exp [4];
    logic         src_seq [4];
    logic         src_exp [4];
    tie_exp = '{8'h11, 8'h22, 8'h11, 8'h22};

    rst_n = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data,  0);
    rst_n = 1;

    // Tie: alternating grants starting from a.
    for (int i = 0; i < 4; i++) begin
      drive(1, 8'h11, 1, 1, 8'h22, 1, 1);
      cycle();
      check("tie_data", out_data, tie_exp[i]);
      check("tie_src",  out_src,  i % 2);
    end

    // Single source b: back-to-back beats, one-cycle latency.
    for (int i = 1; i <= 3; i++) begin
      drive(0, 0, 0, 1, W'(i), 1, 1);
      #1 check("single_b_ready", b_ready, 1);
      #0;
      @(negedge clk);
      // redo as a modelled cycle: the edge already passed, so apply the model by hand
      m_valid = 1; m_data = W'(i); m_last = 1; m_src = 1; m_prio = 0; m_lock = 0; m_lsrc = 1;
      check("single_data", out_data, i);
      check("single_src",  out_src,  1);
    end

    // Backpressure: held beat 3 stays put, no source is ready.
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'h55, 1, 1, 8'h04, 1, 0);
      cycle();
      check("bp_data",  out_data, 8'h03);
      check("bp_valid", out_valid, 1);
    end
    drive(0, 0, 0, 1, 8'h04, 1, 1);
    cycle();
    check("bp_resume_data", out_data, 8'h04);
    drive(0, 0, 0, 0, 0, 0, 1);
    cycle();
    check("bp_drain_valid", out_valid, 0);

    // Packet of 3 a-beats against a constantly valid b.
    begin
      int idx = 0;
      for (int c = 0; c < 4; c++) begin
        drive(idx < 3, W'(8'hA0 + idx), idx == 2, 1, 8'hB0, 1, 1);
        cycle();
        if (last_grant == 1) idx++;
        src_seq[c] = out_src;
      end
    end
`ifdef MUX_LOCK_EN
    src_exp = '{1'b0, 1'b0, 1'b0, 1'b1};
`else
    src_exp = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    for (int c = 0; c < 4; c++) check("pkt_src_seq", src_seq[c], src_exp[c]);

    // a pauses mid-packet while b waits.
    drive(0, 0, 0, 0, 0, 0, 1);
    cycle();
    drive(1, 8'hC0, 0, 1, 8'hD0, 1, 1);
    cycle();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 1, 8'hD0, 1, 1);
`ifdef MUX_LOCK_EN
      #1 check("bubble_b_ready", b_ready, 0);
      #0;
      @(posedge clk);
      #1 check("bubble_out_valid", out_valid, 0);
      m_valid = 0;
      @(negedge clk);
`else
      cycle();
`endif
    end
    drive(1, 8'hC1, 1, 1, 8'hD0, 1, 1);
    cycle();
    drive(0, 0, 0, 1, 8'hD0, 1, 1);
    cycle();
    check("after_pkt_src", out_src, 1);

    // Reset mid-stream while holding a beat.
    drive(1, 8'h77, 1, 0, 0, 0, 0);
    cycle();
    #2 rst_n = 0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_data",  out_data,  0);
    check("midrst_src",   out_src,   0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    drive(1, 8'h31, 1, 1, 8'h32, 1, 1);
    #1 check("post_rst_tie_a", a_ready, 1);
    #0;
    @(negedge clk);
    m_valid = 1; m_data = 8'h31; m_last = 1; m_src = 0; m_prio = 1; m_lock = 0; m_lsrc = 0;

    // Randomized traffic checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 2) == 0,
            $urandom_range(0, 9) < 7);
      if (c == 1500) begin
        #3 rst_n = 0;
        #1 check("rand_rst_valid", out_valid, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
      end else begin
        cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
